// File: rtl/catch_pkg.sv
// Shared encodings for the catch game: referee states and player ids
// (player ids match the ball state machine's ball_state encoding).
package catch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SERVE   = 3'd1,
    ST_HELD    = 3'd2,
    ST_FLIGHT  = 3'd3,
    ST_DROPPED = 3'd4,
    ST_OVER    = 3'd5
  } state_e;

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P1     = 2'd1;
  localparam logic [1:0] P2     = 2'd2;

  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == P1) ? P2 : P1;
  endfunction

  function automatic logic [3:0] score_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/catch_referee_tick_gen.sv
// Game tick divider: down-counter that pulses tick for one cycle every DIV clocks.
module tick_gen #(
  parameter int unsigned DIV = 507812
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == '0) ? W'(DIV - 1) : cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= W'(DIV - 1);
    else          cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/catch_referee.sv
// Catch game referee: serve/hold/flight/drop sequencing, catch arbitration, scoring.
// Optional thrower self-catch after a lockout: define REFEREE_SELF_CATCH_EN.
//
// state   | meaning
// IDLE    | waiting for start, all outputs low
// SERVE   | ball machine held in reset until a glove holds the ball
// HELD    | ball in a glove, waiting for the throw
// FLIGHT  | ball in the air, non-thrower may catch
// DROPPED | point scored, pause before next serve
// OVER    | a player reached WIN_SCORE, waiting for start
module catch_referee
  import catch_pkg::*;
#(
  parameter int unsigned TICK_DIV         = 507812,
  parameter int unsigned FLOOR_MM         = 60,
  parameter int unsigned MAX_FLIGHT_TICKS = 640,
  parameter int unsigned DROP_TICKS       = 256,
  parameter int unsigned WIN_SCORE        = 7,
  parameter int unsigned LOCKOUT_TICKS    = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  ball_state,
  input  logic [15:0] ball_y,
  input  logic        catch_event,
  input  logic        throw_event,
  output logic        ball_reset,
  output logic        can_catch1,
  output logic        can_catch2,
  output logic [2:0]  game_state,
  output logic [1:0]  thrower,
  output logic [3:0]  score1,
  output logic [3:0]  score2,
  output logic [7:0]  rally,
  output logic [1:0]  winner
);

  // Flight counter is wide enough for both the timeout and the lockout compare.
  localparam int unsigned FLIGHT_LIM =
    (MAX_FLIGHT_TICKS > LOCKOUT_TICKS) ? MAX_FLIGHT_TICKS : LOCKOUT_TICKS;
  localparam int unsigned FW = $clog2(FLIGHT_LIM + 1);
  localparam int unsigned DW = (DROP_TICKS > 0) ? $clog2(DROP_TICKS + 1) : 1;

  logic tick;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  logic start_prev_q, catch_prev_q, throw_prev_q;
  logic start_edge_q, catch_edge_q, throw_edge_q;

  state_e        state_q, state_d;
  logic [1:0]    thrower_q, thrower_d;
  logic [3:0]    score1_q, score1_d, score2_q, score2_d;
  logic [7:0]    rally_q, rally_d;
  logic [1:0]    winner_q, winner_d;
  logic [FW-1:0] flight_q, flight_d;
  logic [DW-1:0] drop_q, drop_d;
  logic          ball_reset_q, ball_reset_d;
  logic          cc1_q, cc1_d, cc2_q, cc2_d;
  logic          self_ok;

  always_comb begin
    state_d   = state_q;
    thrower_d = thrower_q;
    score1_d  = score1_q;
    score2_d  = score2_q;
    rally_d   = rally_q;
    winner_d  = winner_q;
    flight_d  = flight_q;
    drop_d    = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (start_edge_q) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (ball_state == P1 || ball_state == P2) begin
          thrower_d = ball_state;
          rally_d   = 8'd0;
          state_d   = ST_HELD;
        end
      end
      ST_HELD: begin
        if (throw_edge_q && ball_state == P_NONE) begin
          flight_d = '0;
          state_d  = ST_FLIGHT;
        end
      end
      ST_FLIGHT: begin
        if (tick && flight_q != FW'(FLIGHT_LIM)) flight_d = flight_q + FW'(1);
        // A catch takes priority over a drop detected in the same cycle.
        if (catch_edge_q && ball_state == other_player(thrower_q)) begin
          rally_d   = (rally_q == 8'hFF) ? rally_q : rally_q + 8'd1;
          thrower_d = ball_state;
          state_d   = ST_HELD;
        end
`ifdef REFEREE_SELF_CATCH_EN
        else if (catch_edge_q && ball_state == thrower_q &&
                 flight_q >= FW'(LOCKOUT_TICKS)) begin
          state_d = ST_HELD;
        end
`endif
        else if ((tick && ball_y < 16'(FLOOR_MM)) ||
                 flight_q == FW'(MAX_FLIGHT_TICKS)) begin
          if (thrower_q == P1) score1_d = score_inc(score1_q);
          else                 score2_d = score_inc(score2_q);
          drop_d  = DW'(DROP_TICKS);
          state_d = ST_DROPPED;
        end
      end
      ST_DROPPED: begin
        if (tick) begin
          if (drop_q <= DW'(1)) begin
            if (score1_q == 4'(WIN_SCORE)) begin
              winner_d = P1;
              state_d  = ST_OVER;
            end else if (score2_q == 4'(WIN_SCORE)) begin
              winner_d = P2;
              state_d  = ST_OVER;
            end else begin
              state_d  = ST_SERVE;
            end
          end else begin
            drop_d = drop_q - DW'(1);
          end
        end
      end
      ST_OVER: begin
        if (start_edge_q) begin
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = P_NONE;
          state_d  = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef REFEREE_SELF_CATCH_EN
  assign self_ok = (flight_d >= FW'(LOCKOUT_TICKS));
`else
  assign self_ok = 1'b0;
`endif

  // Permission outputs follow the next state so they change with game_state.
  always_comb begin
    ball_reset_d = (state_d == ST_SERVE);
    cc1_d = (state_d == ST_FLIGHT) && (thrower_d == P2 || (thrower_d == P1 && self_ok));
    cc2_d = (state_d == ST_FLIGHT) && (thrower_d == P1 || (thrower_d == P2 && self_ok));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      start_prev_q <= 1'b0;
      catch_prev_q <= 1'b0;
      throw_prev_q <= 1'b0;
      start_edge_q <= 1'b0;
      catch_edge_q <= 1'b0;
      throw_edge_q <= 1'b0;
      state_q      <= ST_IDLE;
      thrower_q    <= P_NONE;
      score1_q     <= 4'd0;
      score2_q     <= 4'd0;
      rally_q      <= 8'd0;
      winner_q     <= P_NONE;
      flight_q     <= '0;
      drop_q       <= '0;
      ball_reset_q <= 1'b0;
      cc1_q        <= 1'b0;
      cc2_q        <= 1'b0;
    end else begin
      start_prev_q <= start;
      catch_prev_q <= catch_event;
      throw_prev_q <= throw_event;
      start_edge_q <= start & ~start_prev_q;
      catch_edge_q <= catch_event & ~catch_prev_q;
      throw_edge_q <= throw_event & ~throw_prev_q;
      state_q      <= state_d;
      thrower_q    <= thrower_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      rally_q      <= rally_d;
      winner_q     <= winner_d;
      flight_q     <= flight_d;
      drop_q       <= drop_d;
      ball_reset_q <= ball_reset_d;
      cc1_q        <= cc1_d;
      cc2_q        <= cc2_d;
    end
  end

  assign game_state = state_q;
  assign thrower    = thrower_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign rally      = rally_q;
  assign winner     = winner_q;
  assign ball_reset = ball_reset_q;
  assign can_catch1 = cc1_q;
  assign can_catch2 = cc2_q;

endmodule

// File: tb/tb_catch_referee.sv
// Directed scoreboard bench for catch_referee (TICK_DIV=4, DROP_TICKS=2, WIN_SCORE=2).
module tb_catch_referee;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  ball_state = 2'd0;
  logic [15:0] ball_y = 16'd2000;
  logic        catch_event = 1'b0;
  logic        throw_event = 1'b0;
  logic        ball_reset, can_catch1, can_catch2;
  logic [2:0]  game_state;
  logic [1:0]  thrower, winner;
  logic [3:0]  score1, score2;
  logic [7:0]  rally;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       br, c1, c2;
    logic [1:0] thr;
    logic [3:0] s1, s2;
    logic [7:0] rl;
    logic [1:0] win;
  } snap_t;

  snap_t exp_q[$];

  catch_referee #(
    .TICK_DIV(4), .FLOOR_MM(60), .MAX_FLIGHT_TICKS(640),
    .DROP_TICKS(2), .WIN_SCORE(2), .LOCKOUT_TICKS(32)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ball_state(ball_state),
    .ball_y(ball_y), .catch_event(catch_event), .throw_event(throw_event),
    .ball_reset(ball_reset), .can_catch1(can_catch1), .can_catch2(can_catch2),
    .game_state(game_state), .thrower(thrower), .score1(score1), .score2(score2),
    .rally(rally), .winner(winner)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int st, input bit br, input bit c1, input bit c2,
                      input int thr, input int s1, input int s2, input int rl, input int win);
    snap_t e;
    e.tag = tag; e.st = 3'(st); e.br = br; e.c1 = c1; e.c2 = c2;
    e.thr = 2'(thr); e.s1 = 4'(s1); e.s2 = 4'(s2); e.rl = 8'(rl); e.win = 2'(win);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Waits (bounded, sampling on negedge) for the expected state, then compares every output.
  task automatic pop_check(input int budget);
    snap_t e;
    int n;
    e = exp_q.pop_front();
    n = 0;
    while (game_state !== e.st && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({e.tag, ".state"}, 32'(game_state), 32'(e.st));
    chk({e.tag, ".ball_reset"}, 32'(ball_reset), 32'(e.br));
    chk({e.tag, ".can_catch1"}, 32'(can_catch1), 32'(e.c1));
    chk({e.tag, ".can_catch2"}, 32'(can_catch2), 32'(e.c2));
    chk({e.tag, ".thrower"}, 32'(thrower), 32'(e.thr));
    chk({e.tag, ".score1"}, 32'(score1), 32'(e.s1));
    chk({e.tag, ".score2"}, 32'(score2), 32'(e.s2));
    chk({e.tag, ".rally"}, 32'(rally), 32'(e.rl));
    chk({e.tag, ".winner"}, 32'(winner), 32'(e.win));
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1; cyc(n); start = 1'b0;
  endtask
  task automatic pulse_throw(input int n);
    throw_event = 1'b1; cyc(n); throw_event = 1'b0;
  endtask
  task automatic pulse_catch(input int n);
    catch_event = 1'b1; cyc(n); catch_event = 1'b0;
  endtask

  localparam bit SELF_EN =
`ifdef REFEREE_SELF_CATCH_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    cyc(3);
    @(negedge clk);
    push("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_check(0);
    reset_n = 1'b1;
    cyc(5);

    // start edge: still IDLE one edge later, SERVE on the second
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    push("start_lat1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_check(0);
    @(posedge clk); @(negedge clk);
    push("serve", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    pop_check(0);
    cyc(1); start = 1'b0;

    ball_state = 2'd1;
    push("held1", 2, 0, 0, 0, 1, 0, 0, 0, 0);
    pop_check(10);

    ball_state = 2'd0;
    pulse_throw(6);
    push("flight1", 3, 0, 0, 1, 1, 0, 0, 0, 0);
    pop_check(10);

    // ball exactly at the floor threshold is not a drop; start is ignored in FLIGHT
    ball_y = 16'd60;
    pulse_start(2);
    cyc(20);
    @(negedge clk);
    push("floor_edge", 3, 0, 0, 1, 1, 0, 0, 0, 0);
    pop_check(0);
    ball_y = 16'd2000;

    ball_state = 2'd2;
    pulse_catch(3);
    push("catch2", 2, 0, 0, 0, 2, 0, 0, 1, 0);
    pop_check(10);

    // catch edge while HELD changes nothing
    pulse_catch(3);
    cyc(3);
    @(negedge clk);
    push("catch_in_held", 2, 0, 0, 0, 2, 0, 0, 1, 0);
    pop_check(0);

    ball_state = 2'd0;
    pulse_throw(3);
    push("flight2", 3, 0, 1, 0, 2, 0, 0, 1, 0);
    pop_check(10);

    ball_state = 2'd1;
    pulse_catch(2);
    push("catch1", 2, 0, 0, 0, 1, 0, 0, 2, 0);
    pop_check(10);

    ball_state = 2'd0;
    pulse_throw(2);
    push("flight3", 3, 0, 0, 1, 1, 0, 0, 2, 0);
    pop_check(10);

    ball_y = 16'd30;
    push("drop1", 4, 0, 0, 0, 1, 1, 0, 2, 0);
    pop_check(20);
    ball_y = 16'd2000;
    push("reserve1", 1, 1, 0, 0, 1, 1, 0, 2, 0);
    pop_check(30);

    // two points for player 2
    for (int k = 1; k <= 2; k++) begin
      ball_state = 2'd2;
      push("p2_held", 2, 0, 0, 0, 2, 1, k - 1, 0, 0);
      pop_check(10);
      ball_state = 2'd0;
      pulse_throw(2);
      push("p2_flight", 3, 0, 1, 0, 2, 1, k - 1, 0, 0);
      pop_check(10);
      ball_y = 16'd30;
      push("p2_drop", 4, 0, 0, 0, 2, 1, k, 0, 0);
      pop_check(20);
      ball_y = 16'd2000;
    end
    push("over", 5, 0, 0, 0, 2, 1, 2, 0, 2);
    pop_check(30);

    pulse_start(2);
    push("restart", 1, 1, 0, 0, 2, 0, 0, 0, 0);
    pop_check(10);

    // flight timeout with no catch
    ball_state = 2'd1;
    push("to_held", 2, 0, 0, 0, 1, 0, 0, 0, 0);
    pop_check(10);
    ball_state = 2'd0;
    pulse_throw(2);
    push("to_flight", 3, 0, 0, 1, 1, 0, 0, 0, 0);
    pop_check(10);
    cyc(1200);
    @(negedge clk);
    push("to_mid", 3, 0, SELF_EN, 1, 1, 0, 0, 0, 0);
    pop_check(0);
    push("timeout", 4, 0, 0, 0, 1, 1, 0, 0, 0);
    pop_check(3000);
    push("to_serve", 1, 1, 0, 0, 1, 1, 0, 0, 0);
    pop_check(30);

    // reset in the middle of a flight
    ball_state = 2'd1;
    push("rst_held", 2, 0, 0, 0, 1, 1, 0, 0, 0);
    pop_check(10);
    ball_state = 2'd0;
    pulse_throw(2);
    push("rst_flight", 3, 0, 0, 1, 1, 1, 0, 0, 0);
    pop_check(10);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    @(negedge clk);
    push("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_check(0);
    cyc(4);
    @(negedge clk);
    push("rst_stay", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pop_check(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/catch_referee.md
# catch_referee

Game controller for the catch game. Sequences serve, hold, flight and drop phases around the ball state machine and arbitrates catch permission between the two gloves. Detects dropped balls, keeps score and decides the winner. Sits between the glove trackers and the ball state machine: it drives that machine's `reset`, `can_catch1` and `can_catch2` inputs and consumes its `ball_state`, `ball_y`, `catch_event` and `throw_event`.

## Interface
- `TICK_DIV`, 507812: clk cycles per game tick; 128 Hz at 65 MHz.
- `FLOOR_MM`, 60: a ball with `ball_y` below this value counts as on the floor.
- `MAX_FLIGHT_TICKS`, 640: flight timeout in ticks (5 s).
- `DROP_TICKS`, 256: pause after a drop, in ticks.
- `WIN_SCORE`, 7: points needed to win.
- `LOCKOUT_TICKS`, 32: thrower self-catch lockout; used only with the macro in Configuration.
- `clk` input 1: system clock.
- `reset_n` input 1: synchronous, active-low reset.
- `start` input 1: level; sampled on its rising edge.
- `ball_state` input 2: 0 = air, 1 = held by glove 1, 2 = held by glove 2.
- `ball_y` input 16: ball height in mm.
- `catch_event` input 1: stretched pulse (≥2 cycles).
- `throw_event` input 1: stretched pulse (≥2 cycles).
- `ball_reset` output 1: drives the ball state machine's `reset`.
- `can_catch1` output 1: catch permission for glove 1.
- `can_catch2` output 1: catch permission for glove 2.
- `game_state` output 3: current state encoding.
- `thrower` output 2: last thrower, 0 = none.
- `score1` output 4: score of player 1.
- `score2` output 4: score of player 2.
- `rally` output 8: rally count.
- `winner` output 2: 0 = none, else winning player.

## Operation
- Edge detection:
  - `start`, `catch_event` and `throw_event` are registered once each.
  - Each acts on its rising edge only, so a stretched pulse counts once.
- Tick: an internal counter pulses `tick` for one cycle every `TICK_DIV` cycles.
  - The counter restarts on reset.
  - All tick counts below count `tick` pulses, not clk cycles.
- States, encoded 0–5:
  - **IDLE (0):** all outputs low. A `start` edge goes to SERVE.
  - **SERVE (1):** `ball_reset` is 1. When `ball_state` ≠ 0, latch `thrower` ← `ball_state`, clear `rally`, go to HELD.
  - **HELD (2):** both `can_catch` outputs are 0. A `throw_event` edge while `ball_state` = 0 goes to FLIGHT and clears the flight counter.
  - **FLIGHT (3):**
    - `can_catch` of the non-thrower is 1; the thrower's is 0.
    - A `catch_event` edge with `ball_state` equal to the non-thrower: `rally` +1 (saturates at 255), `thrower` ← catcher, go to HELD.
    - If a tick occurs with `ball_y` < `FLOOR_MM`, or the flight counter reaches `MAX_FLIGHT_TICKS`: the thrower scores +1, go to DROPPED.
  - **DROPPED (4):** waits `DROP_TICKS` ticks. Then go to OVER if either score equals `WIN_SCORE`, otherwise go to SERVE.
  - **OVER (5):** `winner` ← the player at `WIN_SCORE`. A `start` edge clears both scores and `winner`, then goes to SERVE.
- Simultaneous events:
  - A catch edge and a drop condition in the same cycle: the catch wins.
  - A `start` edge is ignored outside IDLE and OVER.
  - A `catch_event` edge in HELD, SERVE or DROPPED is ignored.
- Scores saturate at 15.

## Timing
- All outputs are registered.
- Reset values: state IDLE; all outputs 0; all counters 0.
- Reset asserted mid-game returns to IDLE on the next edge; scores are lost.
- Event latency: a state change happens 2 cycles after the rising edge of the triggering input (1 cycle for edge registration, 1 for the state update).
- `can_catch*` and `ball_reset` update in the same cycle as `game_state`.
- The drop test samples only on `tick` cycles, consistent with the ball position update rate.

## Configuration
- `REFEREE_SELF_CATCH_EN`:
  - **Defined:** in FLIGHT, the thrower's `can_catch` rises once the flight counter reaches `LOCKOUT_TICKS`. A self-catch goes to HELD, leaves `rally` unchanged and awards no point.
  - **Undefined:** the thrower can never catch its own throw, and `LOCKOUT_TICKS` is unused.

## Structure
- Package `catch_pkg`:
  - State enum: `ST_IDLE` … `ST_OVER`.
  - Player encodings: `P_NONE` = 0, `P1` = 1, `P2` = 2.
  - Shared with the ball state machine's `ball_state` encoding.
- Sub-module `tick_gen`: parameterised divider with one-cycle `tick` output.
- FSM, edge detectors and counters live in `catch_referee`.

## Test plan
All directed scenarios use `TICK_DIV` = 4, `DROP_TICKS` = 2, `WIN_SCORE` = 2.
- Serve: `start` edge, then `ball_state` = 1 → `ball_reset` = 1 in SERVE; then HELD with `thrower` = 1 and `ball_reset` = 0.
- Throw/catch: `throw_event` pulse of 6 cycles → FLIGHT once, with `can_catch2` = 1 and `can_catch1` = 0; a catch edge with `ball_state` = 2 → HELD, `rally` = 1, `thrower` = 2.
- Drop: in FLIGHT with `thrower` = 1, `ball_y` = 30 at a tick → DROPPED, `score1` = 1; SERVE after 2 ticks.
- Win: two drops credited to player 2 → OVER with `winner` = 2; a `start` edge → `score2` = 0 and SERVE.
- Reset mid-FLIGHT: `reset_n` low for 1 cycle → IDLE, all outputs 0.
- Timeout: no catch and `ball_y` = 2000 for `MAX_FLIGHT_TICKS` ticks → thrower +1, DROPPED. With `REFEREE_SELF_CATCH_EN`, `can_catch1` rises at tick `LOCKOUT_TICKS`.
